// File: rtl/rdm_rr_pkg.sv
// Shared types and defaults for the round-robin FIFO read manager.
package rdm_pkg;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_SINGLE, S_GAP} rdm_state_t;

  localparam int DW_DEF    = 8;
  localparam int NCH_DEF   = 4;
  localparam int BURST_DEF = 4;

  // Channel index width; keeps a 1-bit index for the single-channel case.
  function automatic int cw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rdm_rr_arb.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arb #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [CW-1:0]  idx,
  output logic           any
);

  logic          hi;
  logic [CW-1:0] hi_idx;
  logic [CW-1:0] lo_idx;

  // Descending scans so the lowest qualifying index wins each pass.
  always_comb begin
    hi     = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (req[j] && (CW'(j) >= ptr)) begin
        hi     = 1'b1;
        hi_idx = CW'(j);
      end
      if (req[j]) lo_idx = CW'(j);
    end
    any = |req;
    idx = hi ? hi_idx : lo_idx;
    gnt = '0;
    for (int j = 0; j < NCH; j++) gnt[j] = any && (CW'(j) == idx);
  end

endmodule

// File: rtl/rdm_rr.sv
// Drains NCH standard-latency FIFOs into one tagged write stream, round-robin,
// bursting from non-almost-empty channels and single-stepping the rest.
module rdm_rr import rdm_pkg::*; #(
  parameter  int DW    = DW_DEF,
  parameter  int NCH   = NCH_DEF,
  parameter  int BURST = BURST_DEF,
  localparam int CW    = cw_of(NCH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NCH-1:0]    iv_fifo_empty,
  input  logic [NCH-1:0]    iv_fifo_ae,
  input  logic [NCH*DW-1:0] iv_fifo_data,
  input  logic              i_dst_af,
  output logic [NCH-1:0]    ov_fifo_rd,
  output logic [DW-1:0]     ov_data,
  output logic [CW-1:0]     ov_data_ch,
  output logic              o_data_wr,
  output logic              o_last
);

  localparam int BCW = (BURST > 1) ? $clog2(BURST + 1) : 1;

  rdm_state_t     state, state_nxt;
  logic [CW-1:0]  ptr, g_q, gnt_idx, ch_p0;
  logic [NCH-1:0] g_oh_q, gnt_oh;
  logic [BCW-1:0] cnt;
  logic           gnt_vld, start, gnt_ae, rd_last, vld_p0, last_p0;

  rr_arb #(.NCH(NCH), .CW(CW)) u_arb (
    .req (~iv_fifo_empty),
    .ptr (ptr),
    .gnt (gnt_oh),
    .idx (gnt_idx),
    .any (gnt_vld)
  );

  assign start  = ~i_dst_af & gnt_vld;
  assign gnt_ae = |(iv_fifo_ae & gnt_oh);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      ptr    <= '0;
      cnt    <= '0;
      g_q    <= '0;
      g_oh_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == S_BURST) ? cnt + BCW'(1) : '0;
      if ((state == S_IDLE) && start) begin
        g_q    <= gnt_idx;
        g_oh_q <= gnt_oh;
        ptr    <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = gnt_ae ? S_SINGLE : S_BURST;
      S_BURST:  if (cnt == BCW'(BURST - 1)) state_nxt = S_IDLE;
      S_SINGLE: state_nxt = S_GAP;
      S_GAP:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ov_fifo_rd = '0;
    rd_last    = 1'b0;
    unique case (state)
      S_BURST: begin
        ov_fifo_rd = g_oh_q;
        rd_last    = (cnt == BCW'(BURST - 1));
      end
      S_SINGLE: begin
        ov_fifo_rd = g_oh_q;
        rd_last    = 1'b1;
      end
      default: ;
    endcase
  end

  // p0: FIFO data is valid this cycle for the strobe issued last cycle
  always_ff @(posedge i_clk) begin
    ch_p0 <= g_q;
    if (i_rst) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= |ov_fifo_rd;
      last_p0 <= rd_last;
    end
  end

  // p1: registered output word
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ov_data    <= '0;
      ov_data_ch <= '0;
      o_data_wr  <= 1'b0;
      o_last     <= 1'b0;
    end else begin
      o_data_wr <= vld_p0;
      o_last    <= vld_p0 & last_p0;
      if (vld_p0) begin
        ov_data    <= iv_fifo_data[ch_p0*DW +: DW];
        ov_data_ch <= ch_p0;
      end
    end
  end

endmodule

// File: tb/tb_rdm_rr.sv
// Bench for rdm_rr: behavioural FIFOs per channel, output scoreboard, grant log.
module tb_rdm_rr;

  localparam int DW = 8, NCH = 4, BURST = 4, CW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              dst_af = 1'b0;
  logic [NCH-1:0]    fifo_empty, fifo_ae, fifo_rd;
  logic [NCH*DW-1:0] fifo_data;
  logic [DW-1:0]     data;
  logic [CW-1:0]     data_ch;
  logic              data_wr, last;

  rdm_rr #(.DW(DW), .NCH(NCH), .BURST(BURST)) dut (
    .i_clk(clk), .i_rst(rst), .iv_fifo_empty(fifo_empty), .iv_fifo_ae(fifo_ae),
    .iv_fifo_data(fifo_data), .i_dst_af(dst_af), .ov_fifo_rd(fifo_rd),
    .ov_data(data), .ov_data_ch(data_ch), .o_data_wr(data_wr), .o_last(last)
  );

  always #5 clk = ~clk;

  // Standard-latency FIFO models: data appears the cycle after the strobe.
  logic [7:0] mem [NCH][64];
  int         wp [NCH] = '{default: 0};
  int         rp [NCH] = '{default: 0};
  logic [7:0] dreg [NCH] = '{default: 8'h00};

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      fifo_empty[k]        = (wp[k] == rp[k]);
      fifo_ae[k]           = ((wp[k] - rp[k]) < BURST);
      fifo_data[k*DW +: DW] = dreg[k];
    end
  end

  always @(posedge clk)
    for (int k = 0; k < NCH; k++)
      if (fifo_rd[k] && (rp[k] != wp[k])) begin
        dreg[k] <= mem[k][rp[k] % 64];
        rp[k]   <= rp[k] + 1;
      end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec = 0, err = 0;

  typedef struct { logic [7:0] data; logic [CW-1:0] ch; logic last; } exp_t;
  exp_t sb[$];

  // Output scoreboard
  always @(negedge clk) begin
    if (data_wr === 1'b1) begin
      vec++;
      if (sb.size() == 0) begin
        err++;
        $display("FAIL extra_word got data=%h ch=%0d last=%b want none", data, data_ch, last);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({data, data_ch, last} !== {e.data, e.ch, e.last}) begin
          err++;
          $display("FAIL out_word got data=%h ch=%0d last=%b want data=%h ch=%0d last=%b",
                   data, data_ch, last, e.data, e.ch, e.last);
        end
      end
    end
  end

  // Grant log: channel, length and start cycle of every strobe run
  int g_ch[$], g_len[$], g_cyc[$];
  logic [NCH-1:0] rd_prev = '0;
  int cur_ch = 0, cur_len = 0, cur_cyc = 0;

  always @(negedge clk) begin
    if (!$onehot0(fifo_rd)) begin
      err++;
      $display("FAIL rd_onehot got=%b want one-hot or zero", fifo_rd);
    end
    if (fifo_rd !== '0 && rd_prev === '0) begin
      cur_len = 1;
      cur_cyc = cyc;
      for (int k = 0; k < NCH; k++) if (fifo_rd[k]) cur_ch = k;
    end else if (fifo_rd !== '0) begin
      cur_len++;
    end
    if (fifo_rd === '0 && rd_prev !== '0) begin
      g_ch.push_back(cur_ch);
      g_len.push_back(cur_len);
      g_cyc.push_back(cur_cyc);
    end
    rd_prev = fifo_rd;
  end

  task automatic check(input string name, input int got, input int want);
    vec++;
    if (got != want) begin
      err++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic load(input int ch, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      mem[ch][wp[ch] % 64] = base + 8'(i);
      wp[ch]++;
    end
  endtask

  task automatic push(input logic [7:0] d, input int ch, input logic l);
    exp_t e;
    e.data = d; e.ch = CW'(ch); e.last = l;
    sb.push_back(e);
  endtask

  // Expected stream for a channel draining alone from n words.
  task automatic exp_lone(input int ch, input int n, input logic [7:0] base, input int first);
    int rem = n;
    int i = first;
    while (rem > 0) begin
      if (rem >= BURST) begin
        for (int j = 0; j < BURST; j++) begin push(base + 8'(i), ch, j == BURST - 1); i++; end
        rem -= BURST;
      end else begin
        push(base + 8'(i), ch, 1'b1); i++; rem--;
      end
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 600) begin @(negedge clk); t++; end
    repeat (8) @(negedge clk);
    check({name, "_pending"}, sb.size(), 0);
  endtask

  task automatic wait_rd(input int ch, input string name);
    int t = 0;
    while (fifo_rd[ch] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    vec++;
    if (fifo_rd[ch] !== 1'b1) begin
      err++;
      $display("FAIL %s_timeout got rd=%b want rd[%0d]=1", name, fifo_rd, ch);
    end
  endtask

  task automatic clear_log();
    g_ch.delete(); g_len.delete(); g_cyc.delete();
  endtask

  typedef struct { int ch; int n; logic [7:0] base; int grants; int len0; int gap; } vec_t;
  vec_t tbl [6];

  initial begin
    int rdc;
    tbl[0] = '{0, 4, 8'h01, 1, 4, 0};
    tbl[1] = '{2, 2, 8'hA0, 2, 1, 3};
    tbl[2] = '{1, 6, 8'h10, 3, 4, 5};
    tbl[3] = '{3, 9, 8'h30, 3, 4, 5};
    tbl[4] = '{3, 1, 8'h55, 1, 1, 0};
    tbl[5] = '{1, 3, 8'h70, 3, 1, 3};

    // Reset held with every FIFO non-empty
    for (int k = 0; k < NCH; k++) begin
      load(k, 1, 8'hC0 + 8'(k));
      push(8'hC0 + 8'(k), k, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("rst_rd", int'(fifo_rd), 0);
      check("rst_wr", int'(data_wr), 0);
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("first_rd", int'(fifo_rd), 1);
    drain("rst_release");

    // Single-channel drains
    foreach (tbl[v]) begin
      clear_log();
      load(tbl[v].ch, tbl[v].n, tbl[v].base);
      exp_lone(tbl[v].ch, tbl[v].n, tbl[v].base, 0);
      drain("tbl");
      check("tbl_grants", g_ch.size(), tbl[v].grants);
      if (g_ch.size() > 0) begin
        check("tbl_ch", g_ch[0], tbl[v].ch);
        check("tbl_len0", g_len[0], tbl[v].len0);
      end
      if (tbl[v].gap != 0 && g_cyc.size() > 1)
        check("tbl_gap", g_cyc[1] - g_cyc[0], tbl[v].gap);
    end

    // Round-robin with all channels bursting
    @(negedge clk); rst = 1'b1;
    @(posedge clk); @(negedge clk); rst = 1'b0;
    clear_log();
    for (int k = 0; k < NCH; k++) load(k, 8, 8'(k * 16));
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NCH; k++)
        for (int i = 0; i < BURST; i++) push(8'(k * 16 + r * 4 + i), k, i == BURST - 1);
    drain("rr");
    check("rr_grants", g_ch.size(), 8);
    for (int i = 0; i < g_ch.size() && i < 8; i++) begin
      check("rr_ch", g_ch[i], i % NCH);
      check("rr_len", g_len[i], BURST);
      if (i > 0) check("rr_spacing", g_cyc[i] - g_cyc[i-1], BURST + 1);
    end

    // Backpressure raised in the second cycle of a ch1 burst
    load(1, 4, 8'hB0);
    exp_lone(1, 4, 8'hB0, 0);
    exp_lone(2, 4, 8'hE0, 0);
    wait_rd(1, "bp_start");
    @(negedge clk);
    dst_af = 1'b1;
    load(2, 4, 8'hE0);
    rdc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd !== '0) rdc++;
    end
    check("bp_rest_reads", rdc, 2);
    dst_af = 1'b0;
    @(posedge clk); @(negedge clk);
    check("bp_resume_rd", int'(fifo_rd), 4);
    drain("bp");

    // Reset on the third read of a burst
    load(1, 8, 8'h40);
    wait_rd(1, "mid_start");
    push(8'h40, 1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("mid_rd", int'(fifo_rd), 0);
    check("mid_wr", int'(data_wr), 0);
    check("mid_left", wp[1] - rp[1], 5);
    load(3, 4, 8'h60);
    for (int i = 3; i < 7; i++) push(8'h40 + 8'(i), 1, i == 6);
    exp_lone(3, 4, 8'h60, 0);
    push(8'h47, 1, 1'b1);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mid_ptr_rd", int'(fifo_rd), 2);
    drain("mid");

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
